// File: rtl/reg_wb_ctrl.sv
// Register writeback controller: tracks pending destination registers, arbitrates
// ALU/LSU results onto the register-file write port and answers operand hazard queries.
module reg_wb_ctrl (
    input  logic        clk,
    input  logic        rst,

    input  logic        issue_valid,
    input  logic [4:0]  issue_rd,
    output logic        issue_ready,

    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    output logic        alu_ready,

    input  logic        lsu_valid,
    input  logic [4:0]  lsu_rd,
    input  logic [31:0] lsu_data,
    output logic        lsu_ready,

    output logic        write_reg,
    output logic [4:0]  target_reg,
    output logic [31:0] write_rd_data,

    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    output logic        rs1_busy,
    output logic        rs2_busy
);

    logic [31:0] pending;
    logic [31:0] pending_nxt;
    logic        acc;
    logic [4:0]  acc_rd;
    logic [31:0] acc_data;
    logic        issue_fire;

    // LSU has fixed priority; the ALU is only offered the port when the LSU is idle.
    always_comb begin
        lsu_ready = rst;
        alu_ready = rst && !lsu_valid;
        acc       = 1'b0;
        acc_rd    = 5'd0;
        acc_data  = 32'd0;
        if (lsu_valid && lsu_ready) begin
            acc      = 1'b1;
            acc_rd   = lsu_rd;
            acc_data = lsu_data;
        end else if (alu_valid && alu_ready) begin
            acc      = 1'b1;
            acc_rd   = alu_rd;
            acc_data = alu_data;
        end
    end

    assign issue_ready = !pending[issue_rd];
    assign issue_fire  = issue_valid && issue_ready && (issue_rd != 5'd0);

    // Clear first, then set: an issue to the register being retired this edge wins.
    always_comb begin
        pending_nxt = pending;
        if (acc) begin
            pending_nxt[acc_rd] = 1'b0;
        end
        if (issue_fire) begin
            pending_nxt[issue_rd] = 1'b1;
        end
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending       <= 32'd0;
            write_reg     <= 1'b0;
            target_reg    <= 5'd0;
            write_rd_data <= 32'd0;
        end else begin
            pending   <= pending_nxt;
            write_reg <= acc && (acc_rd != 5'd0);
            if (acc) begin
                target_reg    <= acc_rd;
                write_rd_data <= acc_data;
            end
        end
    end

    // The write-port term covers the cycle before the register file holds the new value.
    assign rs1_busy = (rs1 != 5'd0) && (pending[rs1] || (write_reg && (target_reg == rs1)));
    assign rs2_busy = (rs2 != 5'd0) && (pending[rs2] || (write_reg && (target_reg == rs2)));

endmodule

// File: tb/tb_reg_wb_ctrl.sv
// Bench for reg_wb_ctrl: directed vector table, reset-abort sequence and a random
// issue/ALU/LSU stream checked against a pending-bitmap model through a scoreboard.
module tb_reg_wb_ctrl;

    logic        clk;
    logic        rst;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        issue_ready;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        alu_ready;
    logic        lsu_valid;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_data;
    logic        lsu_ready;
    logic        write_reg;
    logic [4:0]  target_reg;
    logic [31:0] write_rd_data;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        rs1_busy;
    logic        rs2_busy;

    reg_wb_ctrl dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
        .write_reg(write_reg), .target_reg(target_reg), .write_rd_data(write_rd_data),
        .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        iv;  logic [4:0] ird;
        logic        av;  logic [4:0] ard; logic [31:0] ad;
        logic        lv;  logic [4:0] lrd; logic [31:0] ld;
        logic [4:0]  r1;  logic [4:0] r2;
        logic        e_ir; logic e_ar; logic e_b1; logic e_b2;
        logic        e_wr; logic [4:0] e_tgt; logic [31:0] e_dat;
    } vec_t;

    typedef struct {
        logic        wr;
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_t;

    localparam int NVEC = 22;
    vec_t tbl [NVEC];
    wb_t  sb_q [$];

    int          n_checks = 0;
    int          n_err    = 0;
    logic        cur_wr;
    logic [4:0]  cur_tgt;
    logic [31:0] m_pend;
    logic [4:0]  m_tgt;
    logic [31:0] m_dat;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        issue_valid = v.iv; issue_rd = v.ird;
        alu_valid = v.av; alu_rd = v.ard; alu_data = v.ad;
        lsu_valid = v.lv; lsu_rd = v.lrd; lsu_data = v.ld;
        rs1 = v.r1; rs2 = v.r2;
    endtask

    task automatic idle_inputs();
        issue_valid = 1'b0; issue_rd = 5'd0;
        alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'd0;
        lsu_valid = 1'b0; lsu_rd = 5'd0; lsu_data = 32'd0;
        rs1 = 5'd0; rs2 = 5'd0;
    endtask

    // Pops the expected write-port state for the edge just taken.
    task automatic check_wb(input string nm);
        wb_t e;
        if (sb_q.size() == 0) begin
            chk({nm, "_sb_empty"}, 32'd0, 32'd1);
            cur_wr = 1'b0;
        end else begin
            e = sb_q.pop_front();
            chk({nm, "_write_reg"}, {31'd0, write_reg}, {31'd0, e.wr});
            chk({nm, "_target_reg"}, {27'd0, target_reg}, {27'd0, e.rd});
            chk({nm, "_write_rd_data"}, write_rd_data, e.data);
            cur_wr  = e.wr;
            cur_tgt = e.rd;
        end
    endtask

    function automatic logic [4:0] pick_rd(input logic [31:0] pend);
        logic [4:0] c;
        c = 5'($urandom_range(0, 31));
        for (int k = 0; k < 8; k++) begin
            if (pend[c]) break;
            c = 5'($urandom_range(0, 31));
        end
        return c;
    endfunction

    function automatic logic exp_busy(input logic [4:0] r, input logic [31:0] pend,
                                      input logic wr, input logic [4:0] tgt);
        return (r != 5'd0) && (pend[r] || (wr && (tgt == r)));
    endfunction

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    initial begin
        //             iv ird   av ard ad            lv lrd ld      r1 r2   ir ar b1 b2   wr tgt dat
        tbl[0]  = '{1, 5'd5, 0, 5'd0, 32'h0,        0, 5'd0,  32'h0,  5'd5, 5'd0,  1, 1, 0, 0,  0, 5'd0,  32'h0};
        tbl[1]  = '{0, 5'd0, 1, 5'd5, 32'hDEADBEEF, 0, 5'd0,  32'h0,  5'd5, 5'd0,  1, 1, 1, 0,  1, 5'd5,  32'hDEADBEEF};
        tbl[2]  = '{0, 5'd0, 0, 5'd0, 32'h0,        0, 5'd0,  32'h0,  5'd5, 5'd0,  1, 1, 1, 0,  0, 5'd5,  32'hDEADBEEF};
        tbl[3]  = '{1, 5'd3, 0, 5'd0, 32'h0,        0, 5'd0,  32'h0,  5'd5, 5'd0,  1, 1, 0, 0,  0, 5'd5,  32'hDEADBEEF};
        tbl[4]  = '{1, 5'd4, 0, 5'd0, 32'h0,        0, 5'd0,  32'h0,  5'd3, 5'd4,  1, 1, 1, 0,  0, 5'd5,  32'hDEADBEEF};
        tbl[5]  = '{0, 5'd0, 1, 5'd4, 32'h22,       1, 5'd3,  32'h11, 5'd3, 5'd4,  1, 0, 1, 1,  1, 5'd3,  32'h11};
        tbl[6]  = '{0, 5'd0, 1, 5'd4, 32'h22,       0, 5'd0,  32'h0,  5'd3, 5'd4,  1, 1, 1, 1,  1, 5'd4,  32'h22};
        tbl[7]  = '{0, 5'd0, 0, 5'd0, 32'h0,        0, 5'd0,  32'h0,  5'd3, 5'd4,  1, 1, 0, 1,  0, 5'd4,  32'h22};
        tbl[8]  = '{1, 5'd7, 0, 5'd0, 32'h0,        0, 5'd0,  32'h0,  5'd7, 5'd4,  1, 1, 0, 0,  0, 5'd4,  32'h22};
        tbl[9]  = '{1, 5'd7, 0, 5'd0, 32'h0,        0, 5'd0,  32'h0,  5'd7, 5'd0,  0, 1, 1, 0,  0, 5'd4,  32'h22};
        tbl[10] = '{1, 5'd7, 1, 5'd7, 32'h77,       0, 5'd0,  32'h0,  5'd7, 5'd0,  0, 1, 1, 0,  1, 5'd7,  32'h77};
        tbl[11] = '{1, 5'd7, 0, 5'd0, 32'h0,        0, 5'd0,  32'h0,  5'd7, 5'd0,  1, 1, 1, 0,  0, 5'd7,  32'h77};
        tbl[12] = '{0, 5'd0, 0, 5'd0, 32'h0,        0, 5'd0,  32'h0,  5'd7, 5'd0,  1, 1, 1, 0,  0, 5'd7,  32'h77};
        tbl[13] = '{0, 5'd0, 1, 5'd0, 32'hFFFFFFFF, 0, 5'd0,  32'h0,  5'd0, 5'd7,  1, 1, 0, 1,  0, 5'd0,  32'hFFFFFFFF};
        tbl[14] = '{0, 5'd0, 0, 5'd0, 32'h0,        0, 5'd0,  32'h0,  5'd0, 5'd7,  1, 1, 0, 1,  0, 5'd0,  32'hFFFFFFFF};
        tbl[15] = '{0, 5'd0, 1, 5'd7, 32'h1234,     0, 5'd0,  32'h0,  5'd7, 5'd12, 1, 1, 1, 0,  1, 5'd7,  32'h1234};
        tbl[16] = '{0, 5'd0, 0, 5'd0, 32'h0,        1, 5'd12, 32'hC,  5'd7, 5'd12, 1, 0, 1, 0,  1, 5'd12, 32'hC};
        tbl[17] = '{0, 5'd0, 0, 5'd0, 32'h0,        0, 5'd0,  32'h0,  5'd7, 5'd12, 1, 1, 0, 1,  0, 5'd12, 32'hC};
        tbl[18] = '{0, 5'd0, 0, 5'd0, 32'h0,        0, 5'd0,  32'h0,  5'd7, 5'd12, 1, 1, 0, 0,  0, 5'd12, 32'hC};
        tbl[19] = '{1, 5'd9, 1, 5'd9, 32'h99,       0, 5'd0,  32'h0,  5'd9, 5'd0,  1, 1, 0, 0,  1, 5'd9,  32'h99};
        tbl[20] = '{0, 5'd0, 0, 5'd0, 32'h0,        0, 5'd0,  32'h0,  5'd9, 5'd0,  1, 1, 1, 0,  0, 5'd9,  32'h99};
        tbl[21] = '{0, 5'd9, 0, 5'd0, 32'h0,        0, 5'd0,  32'h0,  5'd9, 5'd0,  0, 1, 1, 0,  0, 5'd9,  32'h99};

        // Reset state
        rst = 1'b0;
        idle_inputs();
        alu_valid = 1'b1; rs1 = 5'd5; rs2 = 5'd9; issue_rd = 5'd3;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_issue_ready", {31'd0, issue_ready}, 32'd1);
        chk("rst_alu_ready",   {31'd0, alu_ready},   32'd0);
        chk("rst_lsu_ready",   {31'd0, lsu_ready},   32'd0);
        chk("rst_rs1_busy",    {31'd0, rs1_busy},    32'd0);
        chk("rst_rs2_busy",    {31'd0, rs2_busy},    32'd0);
        chk("rst_write_reg",   {31'd0, write_reg},   32'd0);
        chk("rst_target_reg",  {27'd0, target_reg},  32'd0);
        chk("rst_wdata",       write_rd_data,        32'd0);
        rst = 1'b1;
        cur_wr = 1'b0;
        cur_tgt = 5'd0;

        // Directed vector table
        for (int i = 0; i < NVEC; i++) begin
            wb_t e;
            drive(tbl[i]);
            #1;
            chk($sformatf("v%0d_issue_ready", i), {31'd0, issue_ready}, {31'd0, tbl[i].e_ir});
            chk($sformatf("v%0d_alu_ready", i),   {31'd0, alu_ready},   {31'd0, tbl[i].e_ar});
            chk($sformatf("v%0d_lsu_ready", i),   {31'd0, lsu_ready},   32'd1);
            chk($sformatf("v%0d_rs1_busy", i),    {31'd0, rs1_busy},    {31'd0, tbl[i].e_b1});
            chk($sformatf("v%0d_rs2_busy", i),    {31'd0, rs2_busy},    {31'd0, tbl[i].e_b2});
            e.wr = tbl[i].e_wr; e.rd = tbl[i].e_tgt; e.data = tbl[i].e_dat;
            sb_q.push_back(e);
            @(posedge clk);
            #1;
            check_wb($sformatf("v%0d", i));
        end

        // Reset asserted mid-cycle while a write is on the port, pending = {2, 9}
        idle_inputs();
        issue_valid = 1'b1; issue_rd = 5'd2;
        alu_valid = 1'b1; alu_rd = 5'd20; alu_data = 32'h55;
        #1;
        chk("ra_issue_ready", {31'd0, issue_ready}, 32'd1);
        @(posedge clk);
        #1;
        issue_valid = 1'b0;
        rs1 = 5'd9; rs2 = 5'd2;
        #1;
        chk("ra_write_reg_pre", {31'd0, write_reg}, 32'd1);
        chk("ra_rs1_busy_pre",  {31'd0, rs1_busy},  32'd1);
        chk("ra_rs2_busy_pre",  {31'd0, rs2_busy},  32'd1);
        #1;
        rst = 1'b0;
        #1;
        chk("ra_write_reg",   {31'd0, write_reg},  32'd0);
        chk("ra_target_reg",  {27'd0, target_reg}, 32'd0);
        chk("ra_wdata",       write_rd_data,       32'd0);
        chk("ra_rs1_busy",    {31'd0, rs1_busy},   32'd0);
        chk("ra_rs2_busy",    {31'd0, rs2_busy},   32'd0);
        chk("ra_alu_ready",   {31'd0, alu_ready},  32'd0);
        chk("ra_lsu_ready",   {31'd0, lsu_ready},  32'd0);
        chk("ra_issue_ready", {31'd0, issue_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        idle_inputs();
        issue_valid = 1'b1; issue_rd = 5'd2;
        #1;
        chk("ra_post_issue_ready", {31'd0, issue_ready}, 32'd1);
        @(posedge clk);
        #1;
        issue_valid = 1'b0; rs1 = 5'd2; rs2 = 5'd9;
        #1;
        chk("ra_post_rs1_busy", {31'd0, rs1_busy}, 32'd1);
        chk("ra_post_rs2_busy", {31'd0, rs2_busy}, 32'd0);
        chk("ra_post_write_reg", {31'd0, write_reg}, 32'd0);

        // Random stream against the bitmap model
        rst = 1'b0;
        idle_inputs();
        @(posedge clk);
        #1;
        rst = 1'b1;
        m_pend = 32'd0; m_tgt = 5'd0; m_dat = 32'd0;
        cur_wr = 1'b0; cur_tgt = 5'd0;
        sb_q.delete();
        for (int c = 0; c < 10000; c++) begin
            wb_t        e;
            logic       acc;
            logic [4:0] a_rd;
            logic [31:0] a_dat;
            issue_valid = 1'($urandom_range(0, 1));
            issue_rd    = 5'($urandom_range(0, 31));
            alu_valid   = ($urandom_range(0, 9) < 5);
            alu_rd      = pick_rd(m_pend);
            alu_data    = $urandom;
            lsu_valid   = ($urandom_range(0, 9) < 3);
            lsu_rd      = pick_rd(m_pend);
            lsu_data    = $urandom;
            rs1         = 5'($urandom_range(0, 31));
            rs2         = pick_rd(m_pend);
            #1;
            chk("rnd_issue_ready", {31'd0, issue_ready}, {31'd0, !m_pend[issue_rd]});
            chk("rnd_alu_ready",   {31'd0, alu_ready},   {31'd0, !lsu_valid});
            chk("rnd_lsu_ready",   {31'd0, lsu_ready},   32'd1);
            chk("rnd_rs1_busy",    {31'd0, rs1_busy},    {31'd0, exp_busy(rs1, m_pend, cur_wr, cur_tgt)});
            chk("rnd_rs2_busy",    {31'd0, rs2_busy},    {31'd0, exp_busy(rs2, m_pend, cur_wr, cur_tgt)});
            acc = 1'b0; a_rd = 5'd0; a_dat = 32'd0;
            if (lsu_valid) begin
                acc = 1'b1; a_rd = lsu_rd; a_dat = lsu_data;
            end else if (alu_valid) begin
                acc = 1'b1; a_rd = alu_rd; a_dat = alu_data;
            end
            if (acc) begin
                m_tgt = a_rd; m_dat = a_dat;
                m_pend[a_rd] = 1'b0;
            end
            if (issue_valid && (issue_rd != 5'd0) && !m_pend[issue_rd] && !(acc && a_rd == issue_rd)) begin
                m_pend[issue_rd] = 1'b1;
            end else if (issue_valid && (issue_rd != 5'd0) && acc && (a_rd == issue_rd) && !dut_view_pending(issue_rd)) begin
                m_pend[issue_rd] = 1'b1;
            end
            m_pend[0] = 1'b0;
            e.wr = acc && (a_rd != 5'd0); e.rd = m_tgt; e.data = m_dat;
            sb_q.push_back(e);
            @(posedge clk);
            #1;
            check_wb("rnd");
        end
        chk("rnd_sb_drained", sb_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    // Pre-edge model view of a pending bit, captured before the accept clear above.
    logic [31:0] m_pend_pre;
    always @(posedge clk) m_pend_pre <= m_pend;

    function automatic logic dut_view_pending(input logic [4:0] r);
        return m_pend_pre[r];
    endfunction

endmodule
